// File: rtl/synaptic_current_accumulator.sv
// Multi-cycle spike-gated weight summer: LANES weights per clock, then clamp (or wrap) to OUT_W bits.
// Optional macro SYN_CUR_SAT_EN enables output saturation; undefined -> two's complement wrap, saturated=0.
module synaptic_current_accumulator #(
    parameter int M     = 24,
    parameter int W     = 8,
    parameter int LANES = 4,
    parameter int OUT_W = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic [M-1:0]       input_spikes,
    input  logic [M*W-1:0]     weights,
    output logic               busy,
    output logic               done,
    output logic [OUT_W-1:0]   input_current,
    output logic               saturated
);

    localparam int N     = M / LANES;
    localparam int ACC_W = W + $clog2(M) + 1;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {IDLE, ACCUM, FINISH} state_t;

    state_t                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic [M-1:0]              spk_q, spk_d;
    logic [M*W-1:0]            wts_q, wts_d;
    logic [OUT_W-1:0]          cur_q, cur_d;
    logic                      sat_q, sat_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic signed [ACC_W-1:0]   chunk_sum;
    logic [OUT_W-1:0]          res_val;
    logic                      res_sat;

    function automatic logic [ACC_W-1:0] sext(input logic [W-1:0] w);
        return {{(ACC_W-W){w[W-1]}}, w};
    endfunction

    always_comb begin
        chunk_sum = '0;
        for (int l = 0; l < LANES; l++) begin
            if (spk_q[int'(cnt_q) * LANES + l])
                chunk_sum = chunk_sum + sext(wts_q[(int'(cnt_q) * LANES + l) * W +: W]);
        end
    end

`ifdef SYN_CUR_SAT_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((2 ** (OUT_W - 1)) - 1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ACC_W'(-(2 ** (OUT_W - 1)));

    always_comb begin
        res_val = acc_q[OUT_W-1:0];
        res_sat = 1'b0;
        if (acc_q > SAT_MAX) begin
            res_val = {1'b0, {(OUT_W-1){1'b1}}};
            res_sat = 1'b1;
        end else if (acc_q < SAT_MIN) begin
            res_val = {1'b1, {(OUT_W-1){1'b0}}};
            res_sat = 1'b1;
        end
    end
`else
    assign res_val = acc_q[OUT_W-1:0];
    assign res_sat = 1'b0;
`endif

    // Inputs are captured once at acceptance; start is ignored outside IDLE.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        spk_d   = spk_q;
        wts_d   = wts_q;
        cur_d   = cur_q;
        sat_d   = sat_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    spk_d   = input_spikes;
                    wts_d   = weights;
                    acc_d   = '0;
                    cnt_d   = '0;
                    busy_d  = 1'b1;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                acc_d = acc_q + chunk_sum;
                if (cnt_q == CNT_W'(N - 1))
                    state_d = FINISH;
                else
                    cnt_d = cnt_q + 1'b1;
            end
            FINISH: begin
                cur_d   = res_val;
                sat_d   = res_sat;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            spk_q   <= '0;
            wts_q   <= '0;
            cur_q   <= '0;
            sat_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            spk_q   <= spk_d;
            wts_q   <= wts_d;
            cur_q   <= cur_d;
            sat_q   <= sat_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy          = busy_q;
    assign done          = done_q;
    assign input_current = cur_q;
    assign saturated     = sat_q;

endmodule

// File: tb/tb_synaptic_current_accumulator.sv
// Randomized and directed bench for synaptic_current_accumulator against an arithmetic reference model.
// Honours SYN_CUR_SAT_EN the same way the design does.
module tb_synaptic_current_accumulator;

    localparam int M     = 24;
    localparam int W     = 8;
    localparam int LANES = 4;
    localparam int OUT_W = 8;
    localparam int N     = M / LANES;

    logic               clk = 1'b0;
    logic               reset;
    logic               start;
    logic [M-1:0]       input_spikes;
    logic [M*W-1:0]     weights;
    logic               busy;
    logic               done;
    logic [OUT_W-1:0]   input_current;
    logic               saturated;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    synaptic_current_accumulator #(.M(M), .W(W), .LANES(LANES), .OUT_W(OUT_W)) dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .input_spikes  (input_spikes),
        .weights       (weights),
        .busy          (busy),
        .done          (done),
        .input_current (input_current),
        .saturated     (saturated)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            failures++;
            $display("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: plain integer sum of gated weights, then clamp or wrap.
    function automatic void modelResult(input logic [M-1:0] spk, input logic [M*W-1:0] wts,
                                        output logic [OUT_W-1:0] cur, output logic sat);
        int sum = 0;
        logic signed [W-1:0] w;
        for (int i = 0; i < M; i++) begin
            w = wts[i*W +: W];
            if (spk[i]) sum += int'(w);
        end
`ifdef SYN_CUR_SAT_EN
        if (sum > (2 ** (OUT_W - 1)) - 1) begin
            cur = OUT_W'((2 ** (OUT_W - 1)) - 1);
            sat = 1'b1;
        end else if (sum < -(2 ** (OUT_W - 1))) begin
            cur = OUT_W'(-(2 ** (OUT_W - 1)));
            sat = 1'b1;
        end else begin
            cur = OUT_W'(sum);
            sat = 1'b0;
        end
`else
        cur = OUT_W'(sum);
        sat = 1'b0;
`endif
    endfunction

    task automatic applyStimulus(input logic [M-1:0] spk, input logic [M*W-1:0] wts, output int latency);
        @(negedge clk);
        input_spikes = spk;
        weights      = wts;
        start        = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        checkOutput("busy_after_accept", busy, 1);
        latency = 0;
        while (done !== 1'b1 && latency < 40) begin
            @(posedge clk);
            #1;
            latency++;
        end
        checkOutput("done_seen", done, 1);
        checkOutput("busy_at_done", busy, 0);
    endtask

    task automatic runAndCheck(input string tag, input logic [M-1:0] spk, input logic [M*W-1:0] wts);
        int lat;
        logic [OUT_W-1:0] exp_cur;
        logic exp_sat;
        modelResult(spk, wts, exp_cur, exp_sat);
        applyStimulus(spk, wts, lat);
        checkOutput({tag, "_latency"}, lat, N + 1);
        checkOutput({tag, "_current"}, input_current, exp_cur);
        checkOutput({tag, "_saturated"}, saturated, exp_sat);
    endtask

    // busy and done must be mutually exclusive on every cycle.
    always @(negedge clk) checkOutput("busy_done_excl", busy & done, 0);

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation time limit exceeded");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [M-1:0]     spk, spk_b;
        logic [M*W-1:0]   wts, wts_b;
        logic [OUT_W-1:0] exp_cur, got_cur;
        logic             exp_sat, got_sat;
        int               pulses, last, lat;

        reset = 1'b1;
        start = 1'b0;
        input_spikes = '0;
        weights = '0;
        repeat (2) @(negedge clk);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_current", input_current, 0);
        checkOutput("reset_saturated", saturated, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // Spikes 0 and 23: 50 + (-20) = 30.
        spk = '0; spk[0] = 1'b1; spk[M-1] = 1'b1;
        for (int i = 0; i < M; i++) wts[i*W +: W] = 8'h7F;
        wts[0 +: W] = 8'd50;
        wts[(M-1)*W +: W] = 8'(-20);
        applyStimulus(spk, wts, lat);
        checkOutput("tp1_latency", lat, 7);
        checkOutput("tp1_current", input_current, 30);
        checkOutput("tp1_saturated", saturated, 0);

        // All spikes, weights 10: sum 240.
        spk = '1;
        for (int i = 0; i < M; i++) wts[i*W +: W] = 8'd10;
        applyStimulus(spk, wts, lat);
`ifdef SYN_CUR_SAT_EN
        checkOutput("tp2_current", input_current, 8'h7F);
        checkOutput("tp2_saturated", saturated, 1);
`else
        checkOutput("tp2_current", input_current, 8'hF0);
        checkOutput("tp2_saturated", saturated, 0);
`endif

        // Spikes 0,1 with -100: sum -200.
        spk = '0; spk[0] = 1'b1; spk[1] = 1'b1;
        for (int i = 0; i < M; i++) wts[i*W +: W] = 8'(-100);
        applyStimulus(spk, wts, lat);
`ifdef SYN_CUR_SAT_EN
        checkOutput("tp3_current", input_current, 8'h80);
        checkOutput("tp3_saturated", saturated, 1);
`else
        checkOutput("tp3_current", input_current, 8'h38);
        checkOutput("tp3_saturated", saturated, 0);
`endif

        runAndCheck("zero_spikes", '0, wts);

        // Inputs and start change during ACCUM; only the snapshot counts.
        spk = M'($urandom);
        for (int i = 0; i < M; i++) wts[i*W +: W] = 8'($urandom_range(0, 255));
        spk_b = ~spk;
        for (int i = 0; i < M; i++) wts_b[i*W +: W] = 8'($urandom_range(0, 255));
        modelResult(spk, wts, exp_cur, exp_sat);
        @(negedge clk);
        input_spikes = spk; weights = wts; start = 1'b1;
        @(negedge clk);
        input_spikes = spk_b; weights = wts_b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        pulses = 0; got_cur = '0; got_sat = 1'b0;
        repeat (16) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                got_cur = input_current;
                got_sat = saturated;
            end
        end
        checkOutput("snap_pulses", pulses, 1);
        checkOutput("snap_current", got_cur, exp_cur);
        checkOutput("snap_saturated", got_sat, exp_sat);

        // Reset during chunk 3 aborts without a done pulse.
        spk = '1;
        for (int i = 0; i < M; i++) wts[i*W +: W] = 8'd3;
        runAndCheck("pre_reset", spk, wts);
        @(negedge clk);
        input_spikes = spk; weights = wts; start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        checkOutput("midrst_busy", busy, 0);
        checkOutput("midrst_done", done, 0);
        checkOutput("midrst_current", input_current, 0);
        checkOutput("midrst_saturated", saturated, 0);
        @(negedge clk);
        reset = 1'b0;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done) pulses++;
        end
        checkOutput("midrst_no_done", pulses, 0);
        checkOutput("midrst_current_held", input_current, 0);
        runAndCheck("post_reset", spk, wts);

        // start held high: one result every N+2 cycles.
        spk = '1;
        for (int i = 0; i < M; i++) wts[i*W +: W] = 8'd1;
        @(negedge clk);
        input_spikes = spk; weights = wts; start = 1'b1;
        pulses = 0; last = -1;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            @(posedge clk);
            #1;
            if (done) begin
                pulses++;
                checkOutput("held_current", input_current, 24);
                checkOutput("held_saturated", saturated, 0);
                if (last >= 0) checkOutput("held_period", cyc - last, N + 2);
                last = cyc;
            end
        end
        @(negedge clk);
        start = 1'b0;
        checkOutput("held_pulses", pulses >= 4, 1);
        repeat (12) @(posedge clk);

        // Random operands; odd iterations bias towards large positive or negative weights.
        for (int it = 0; it < 30; it++) begin
            spk = M'($urandom);
            for (int i = 0; i < M; i++) begin
                if (it % 4 == 1)      wts[i*W +: W] = 8'($urandom_range(64, 127));
                else if (it % 4 == 3) wts[i*W +: W] = 8'($urandom_range(128, 192));
                else                  wts[i*W +: W] = 8'($urandom_range(0, 255));
            end
            runAndCheck("random", spk, wts);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
